// File: rtl/framebuffer_sink.sv
`default_nettype none
// ============================================================================
//  Module      : framebuffer_sink
//  Description : Captures pixels from the vga_x/vga_y/vga_colour/vga_plot
//                interface into an on-chip framebuffer and streams the whole
//                frame back out in raster order over a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_sink #(
    parameter int SCR_W = 160,
    parameter int SCR_H = 120,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    vga_x,
    input  logic [6:0]    vga_y,
    input  logic [CW-1:0] vga_colour,
    input  logic          vga_plot,
    input  logic          scan_start,
    output logic          scan_busy,
    output logic          scan_done,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [7:0]    pix_x,
    output logic [6:0]    pix_y,
    output logic [CW-1:0] pix_colour,
    output logic [15:0]   plot_count,
    output logic          oob_err
);

    localparam int         c_depth  = SCR_W * SCR_H;
    localparam logic [7:0] c_x_lim  = 8'(SCR_W);
    localparam logic [6:0] c_y_lim  = 7'(SCR_H);
    localparam logic [7:0] c_x_last = 8'(SCR_W - 1);
    localparam logic [6:0] c_y_last = 7'(SCR_H - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // y*160 + x built from shifts so no multiplier is inferred
    function automatic logic [14:0] f_addr(input logic [7:0] x, input logic [6:0] y);
        return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
    endfunction

    logic [CW-1:0] r_mem [c_depth];

    state_t        r_state;
    state_t        w_state_nxt;

    logic [7:0]    r_rd_x;
    logic [6:0]    r_rd_y;
    logic [CW-1:0] r_rd_data;
    logic          r_rd_vld;
    logic [7:0]    r_rd_px;
    logic [6:0]    r_rd_py;

    logic          r_pix_valid;
    logic [7:0]    r_pix_x;
    logic [6:0]    r_pix_y;
    logic [CW-1:0] r_pix_colour;

    logic [15:0]   r_plot_count;
    logic          r_oob_err;
    logic          r_scan_done;

    logic          w_wr_in;
    logic          w_wr_en;
    logic          w_wr_oob;
    logic [14:0]   w_wr_addr;
    logic [14:0]   w_rd_addr;
    logic          w_adv;
    logic          w_issue;
    logic          w_rd_x_end;
    logic          w_rd_last;
    logic          w_last_acc;

    assign w_wr_in    = (vga_x < c_x_lim) && (vga_y < c_y_lim);
    assign w_wr_en    = vga_plot && w_wr_in;
    assign w_wr_oob   = vga_plot && !w_wr_in;
    assign w_wr_addr  = f_addr(vga_x, vga_y);
    assign w_rd_addr  = f_addr(r_rd_x, r_rd_y);

    // Both pipeline stages move together whenever the output slot frees up
    assign w_adv      = !r_pix_valid || pix_ready;
    assign w_rd_x_end = (r_rd_x == c_x_last);
    assign w_rd_last  = w_rd_x_end && (r_rd_y == c_y_last);
    assign w_last_acc = r_pix_valid && pix_ready
                        && (r_pix_x == c_x_last) && (r_pix_y == c_y_last);

    // Frame store: no reset so contents survive rst; read-before-write on collision
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= vga_colour;
        end
        if (w_issue) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (scan_start) begin
                    w_state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                w_issue = w_adv;
                if (w_adv && w_rd_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_last_acc) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Raster read counter; parked at (0,0) whenever no scan is running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_x <= '0;
            r_rd_y <= '0;
        end else if (r_state == S_IDLE) begin
            r_rd_x <= '0;
            r_rd_y <= '0;
        end else if (w_issue) begin
            if (w_rd_x_end) begin
                r_rd_x <= '0;
                r_rd_y <= (r_rd_y == c_y_last) ? 7'd0 : r_rd_y + 7'd1;
            end else begin
                r_rd_x <= r_rd_x + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_vld     <= 1'b0;
            r_rd_px      <= '0;
            r_rd_py      <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pix_colour <= '0;
        end else if (w_adv) begin
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_rd_px <= r_rd_x;
                r_rd_py <= r_rd_y;
            end
            r_pix_valid <= r_rd_vld;
            if (r_rd_vld) begin
                r_pix_x      <= r_rd_px;
                r_pix_y      <= r_rd_py;
                r_pix_colour <= r_rd_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_plot_count <= '0;
            r_oob_err    <= 1'b0;
            r_scan_done  <= 1'b0;
        end else begin
            if (w_wr_en && (r_plot_count != 16'hFFFF)) begin
                r_plot_count <= r_plot_count + 16'd1;
            end
            if (w_wr_oob) begin
                r_oob_err <= 1'b1;
            end
            r_scan_done <= (r_state == S_DRAIN) && w_last_acc;
        end
    end

    assign scan_busy  = (r_state != S_IDLE);
    assign scan_done  = r_scan_done;
    assign pix_valid  = r_pix_valid;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign pix_colour = r_pix_colour;
    assign plot_count = r_plot_count;
    assign oob_err    = r_oob_err;

endmodule
`default_nettype wire

// File: doc/framebuffer_sink.md
Name: framebuffer_sink

Overview:
- Receiving end of the pixel-plot interface (vga_x / vga_y / vga_colour / vga_plot) driven by fillscreen and the other drawing engines.
- Stores each plotted pixel in an on-chip 160x120 colour framebuffer.
- On request, streams the whole frame back out in raster order over a valid/ready pixel interface, for checking or for scan-out.

Parameters:
- SCR_W, 160, screen width in pixels; legal x is 0..SCR_W-1.
- SCR_H, 120, screen height in pixels; legal y is 0..SCR_H-1.
- CW, 3, colour width in bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- vga_x  in  8  plot x coordinate.
- vga_y  in  7  plot y coordinate.
- vga_colour  in  CW  plot colour.
- vga_plot  in  1  write strobe; one pixel per cycle while high.
- scan_start  in  1  request a full-frame readback; sampled only in IDLE.
- scan_busy  out  1  high in SCAN and DRAIN.
- scan_done  out  1  one-cycle pulse after the last pixel is accepted.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  consumer accepts the output pixel.
- pix_x  out  8  x of the output pixel.
- pix_y  out  7  y of the output pixel.
- pix_colour  out  CW  colour of the output pixel.
- plot_count  out  16  number of accepted in-range plots; saturates at 65535.
- oob_err  out  1  sticky; set by any out-of-range plot.

Behaviour:
- Reset (async, immediate):
  - scan_busy, scan_done, pix_valid and oob_err = 0.
  - pix_x, pix_y, pix_colour and plot_count = 0.
  - FSM returns to IDLE.
  - Memory contents are NOT cleared; they are retained across reset.
- Memory: SCR_W*SCR_H x CW, simple dual-port, synchronous read with 1-cycle latency.
  - Address = y*160 + x, 15 bits, computed as (y<<7)+(y<<5)+x with no multiplier.
- Write side (active in every state):
  - On a rising edge with vga_plot=1, x<SCR_W and y<SCR_H: write the colour and increment plot_count (saturating).
  - If vga_plot=1 and the coordinate is out of range: no write, plot_count unchanged, oob_err<=1 until rst.
- FSM states: IDLE, SCAN, DRAIN.
  - IDLE -> SCAN when scan_start=1; the read address counter starts at (0,0).
  - In SCAN, the read counter advances (x first, then y; x wraps 159->0 with y+1) only when the output slot is free or being accepted, i.e. !pix_valid || pix_ready.
  - SCAN -> DRAIN after the read of (159,119) is issued.
  - DRAIN -> IDLE when the (159,119) beat is accepted; scan_done pulses in the following cycle.
  - scan_start is ignored while scan_busy=1.
- Output handshake:
  - A beat transfers on a cycle with pix_valid && pix_ready.
  - While pix_valid=1 && pix_ready=0, pix_x, pix_y and pix_colour hold stable.
  - pix_valid never drops without a transfer, except on rst.
  - Exactly SCR_W*SCR_H beats per scan, in raster order, no gaps or duplicates.
  - With pix_ready held at 1: first beat 2 cycles after scan_start is sampled, then one beat per cycle.
- Write/read interaction:
  - A plot during a scan to a pixel not yet read appears in the stream.
  - A plot to a pixel already read does not appear.
  - A read and a write to the same address on the same edge return the OLD value.
- Reset mid-scan: outputs drop immediately. The next scan_start restarts from (0,0) and shows the retained memory contents.

Test Plan:
- Full fill then scan: rst; plot all 19200 pixels with colour=(x+y)%8; scan_start with pix_ready=1 -> plot_count=19200; 19200 beats, first (0,0,0), last (159,119,6); first beat 2 cycles after scan_start; scan_done pulses the cycle after the last beat; scan_busy=0 afterwards.
- Out of range: plot (160,5,7) and then (3,120,7) -> oob_err=1 and stays 1; plot_count unchanged; a rescan shows (0,5) and (3,0) unchanged.
- Backpressure: pix_ready driven by an LFSR (~50% duty) -> identical beat sequence to the full-fill scan; outputs stable on every stalled cycle.
- Busy ignore: pulse scan_start again at beat 100 -> exactly 19200 beats and exactly one scan_done.
- Async reset mid-scan: assert rst at beat 500 between clock edges -> pix_valid=0 and scan_busy=0 before the next edge; the next scan starts at (0,0) with the earlier colours intact.
- Same-cycle collision:
  - During a scan, plot (10,0,colour 5) on the same edge the read of (10,0) is issued -> beat (10,0) carries the old colour, and the next scan shows 5.
  - Plot (159,119) at beat 1000 -> the new colour appears in the final beat.
